// File: rtl/ca_code_nco_gen.sv
`default_nettype none
// ============================================================================
// Module   : ca_code_nco_gen
// Brief    : GPS L1 C/A Gold-code generator, run-time PRN 1..32, programmable
//            chip divider. Optional early/late taps via CA_EPL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ca_code_nco_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 en,
  input  logic [5:0]           prn_sel,
  input  logic [DIV_WIDTH-1:0] div_val,
  output logic                 chip_out,
  output logic                 chip_early,
  output logic                 chip_late,
  output logic                 chip_stb,
  output logic                 epoch,
  output logic [9:0]           chip_idx,
  output logic                 running,
  output logic                 prn_err
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [9:0]           c_LFSR_SEED = 10'h3FF;
  localparam logic [9:0]           c_LAST_CHIP = 10'd1022;
  localparam logic [DIV_WIDTH-1:0] c_DIV_ONE   = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  state_t               r_state;
  state_t               w_state_next;
  logic [9:0]           r_g1;
  logic [9:0]           r_g2;
  logic [9:0]           w_g1_next;
  logic [9:0]           w_g2_next;
  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic [9:0]           r_chip_idx;
  logic [4:0]           r_prn;
  logic                 r_prn_err;
  logic                 r_chip_stb;
  logic                 r_epoch;
  logic                 w_prn_ok;
  logic                 w_running;
  logic                 w_advance;
  logic [7:0]           w_taps;
  logic [3:0]           w_tap_a;
  logic [3:0]           w_tap_b;
  logic                 w_chip_prompt;

  // G2 phase-selector taps as {bit_a, bit_b} (stage number minus one), index = PRN-1
  function automatic logic [7:0] g2_taps(input logic [4:0] p);
    case (p)
      5'd0:    g2_taps = {4'd1, 4'd5};
      5'd1:    g2_taps = {4'd2, 4'd6};
      5'd2:    g2_taps = {4'd3, 4'd7};
      5'd3:    g2_taps = {4'd4, 4'd8};
      5'd4:    g2_taps = {4'd0, 4'd8};
      5'd5:    g2_taps = {4'd1, 4'd9};
      5'd6:    g2_taps = {4'd0, 4'd7};
      5'd7:    g2_taps = {4'd1, 4'd8};
      5'd8:    g2_taps = {4'd2, 4'd9};
      5'd9:    g2_taps = {4'd1, 4'd2};
      5'd10:   g2_taps = {4'd2, 4'd3};
      5'd11:   g2_taps = {4'd4, 4'd5};
      5'd12:   g2_taps = {4'd5, 4'd6};
      5'd13:   g2_taps = {4'd6, 4'd7};
      5'd14:   g2_taps = {4'd7, 4'd8};
      5'd15:   g2_taps = {4'd8, 4'd9};
      5'd16:   g2_taps = {4'd0, 4'd3};
      5'd17:   g2_taps = {4'd1, 4'd4};
      5'd18:   g2_taps = {4'd2, 4'd5};
      5'd19:   g2_taps = {4'd3, 4'd6};
      5'd20:   g2_taps = {4'd4, 4'd7};
      5'd21:   g2_taps = {4'd5, 4'd8};
      5'd22:   g2_taps = {4'd0, 4'd2};
      5'd23:   g2_taps = {4'd3, 4'd5};
      5'd24:   g2_taps = {4'd4, 4'd6};
      5'd25:   g2_taps = {4'd5, 4'd7};
      5'd26:   g2_taps = {4'd6, 4'd8};
      5'd27:   g2_taps = {4'd7, 4'd9};
      5'd28:   g2_taps = {4'd0, 4'd5};
      5'd29:   g2_taps = {4'd1, 4'd6};
      5'd30:   g2_taps = {4'd2, 4'd7};
      default: g2_taps = {4'd3, 4'd8};
    endcase
  endfunction

  assign w_prn_ok  = (prn_sel != 6'd0) && (prn_sel <= 6'd32);
  assign w_running = (r_state == S_RUN);
  assign w_advance = w_running && en && (r_div_cnt == '0);

  assign w_taps  = g2_taps(r_prn);
  assign w_tap_a = w_taps[7:4];
  assign w_tap_b = w_taps[3:0];

  assign w_g1_next = {r_g1[8:0], r_g1[2] ^ r_g1[9]};
  assign w_g2_next = {r_g2[8:0], ^{r_g2[1], r_g2[2], r_g2[5], r_g2[7], r_g2[8], r_g2[9]}};

  assign w_chip_prompt = r_g1[9] ^ r_g2[w_tap_a] ^ r_g2[w_tap_b];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (start) begin
      w_state_next = w_prn_ok ? S_RUN : S_IDLE;
    end
  end

  // start outranks the divider, so a start on a chip boundary discards the shift
  always_ff @(posedge clk) begin
    if (rst) begin
      r_g1       <= c_LFSR_SEED;
      r_g2       <= c_LFSR_SEED;
      r_div_cnt  <= '0;
      r_chip_idx <= '0;
      r_prn      <= '0;
      r_prn_err  <= 1'b0;
      r_chip_stb <= 1'b0;
      r_epoch    <= 1'b0;
    end else begin
      r_chip_stb <= 1'b0;
      r_epoch    <= 1'b0;
      if (start) begin
        r_prn_err <= ~w_prn_ok;
        if (w_prn_ok) begin
          r_prn      <= prn_sel[4:0] - 5'd1;
          r_g1       <= c_LFSR_SEED;
          r_g2       <= c_LFSR_SEED;
          r_chip_idx <= '0;
          r_div_cnt  <= div_val;
          r_chip_stb <= 1'b1;
          r_epoch    <= 1'b1;
        end
      end else if (w_running && en) begin
        if (r_div_cnt != '0) begin
          r_div_cnt <= r_div_cnt - c_DIV_ONE;
        end else begin
          r_g1       <= w_g1_next;
          r_g2       <= w_g2_next;
          r_chip_idx <= (r_chip_idx == c_LAST_CHIP) ? 10'd0 : r_chip_idx + 10'd1;
          r_div_cnt  <= div_val;
          r_chip_stb <= 1'b1;
          r_epoch    <= (r_chip_idx == c_LAST_CHIP);
        end
      end
    end
  end

`ifdef CA_EPL_EN
  logic r_late;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_late <= 1'b0;
    end else if (start) begin
      if (w_prn_ok) begin
        r_late <= 1'b0;
      end
    end else if (w_advance) begin
      r_late <= chip_out;
    end
  end

  assign chip_early = w_running & (w_g1_next[9] ^ w_g2_next[w_tap_a] ^ w_g2_next[w_tap_b]);
  assign chip_late  = w_running & r_late;
`else
  assign chip_early = 1'b0;
  assign chip_late  = 1'b0;
`endif

  assign chip_out = w_running & w_chip_prompt;
  assign chip_stb = r_chip_stb;
  assign epoch    = r_epoch;
  assign chip_idx = r_chip_idx;
  assign running  = w_running;
  assign prn_err  = r_prn_err;

endmodule
`default_nettype wire

// File: tb/tb_ca_code_nco_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ca_code_nco_gen
// Brief    : Self-checking bench for ca_code_nco_gen (vector table + sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ca_code_nco_gen;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          en;
  logic [5:0]    prn_sel;
  logic [DW-1:0] div_val;
  logic          chip_out;
  logic          chip_early;
  logic          chip_late;
  logic          chip_stb;
  logic          epoch;
  logic [9:0]    chip_idx;
  logic          running;
  logic          prn_err;

  int checks = 0;
  int errors = 0;

  bit mseq [0:1022];

  typedef struct {
    logic [5:0]    prn;
    logic [DW-1:0] dv;
    logic [9:0]    bits;
  } vec_t;

  vec_t vecs [0:4];

  always #5 clk = ~clk;

  ca_code_nco_gen #(.DIV_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .en         (en),
    .prn_sel    (prn_sel),
    .div_val    (div_val),
    .chip_out   (chip_out),
    .chip_early (chip_early),
    .chip_late  (chip_late),
    .chip_stb   (chip_stb),
    .epoch      (epoch),
    .chip_idx   (chip_idx),
    .running    (running),
    .prn_err    (prn_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [5:0] p, input logic [DW-1:0] d);
    prn_sel = p;
    div_val = d;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Independent Gold-code model: stage arrays numbered 1..10 as in the ICD
  task automatic gen_seq(input int a, input int b);
    bit s1 [1:10];
    bit s2 [1:10];
    bit f1;
    bit f2;
    for (int i = 1; i <= 10; i++) begin
      s1[i] = 1'b1;
      s2[i] = 1'b1;
    end
    for (int n = 0; n < 1023; n++) begin
      mseq[n] = s1[10] ^ s2[a] ^ s2[b];
      f1 = s1[3] ^ s1[10];
      f2 = s2[2] ^ s2[3] ^ s2[6] ^ s2[8] ^ s2[9] ^ s2[10];
      for (int i = 10; i >= 2; i--) begin
        s1[i] = s1[i-1];
        s2[i] = s2[i-1];
      end
      s1[1] = f1;
      s2[1] = f2;
    end
  endtask

  initial begin
    int per;
    int k;
    int n;
    int bad_stb;
    int bad_idx;
    int bad_hold;
    int bad_a;
    int bad_b;
    int bad_c;
    logic [9:0] word;

    vecs[0] = '{prn: 6'd1,  dv: 16'd0, bits: 10'o1440};
    vecs[1] = '{prn: 6'd2,  dv: 16'd3, bits: 10'o1620};
    vecs[2] = '{prn: 6'd10, dv: 16'd1, bits: 10'o1504};
    vecs[3] = '{prn: 6'd17, dv: 16'd2, bits: 10'o1156};
    vecs[4] = '{prn: 6'd32, dv: 16'd0, bits: 10'o1712};

    // reset with start held: reset must win
    rst = 1'b1; start = 1'b1; en = 1'b1; prn_sel = 6'd1; div_val = '0;
    tick();
    tick();
    check("reset_outs", {chip_out, chip_early, chip_late, chip_stb, epoch, running, prn_err, chip_idx}, 32'd0);
    check("reset_lfsr", {dut.r_g1, dut.r_g2}, 32'hFFFFF);
    rst = 1'b0; start = 1'b0;
    tick();
    check("idle_after_reset", {running, chip_stb, chip_out}, 32'd0);

    for (int v = 0; v < 5; v++) begin
      per = int'(vecs[v].dv) + 1;
      do_start(vecs[v].prn, vecs[v].dv);
      word = '0; bad_stb = 0; bad_idx = 0; bad_hold = 0;
      for (int c = 0; c < 10 * per; c++) begin
        k = c / per;
        if (c % per == 0) word[9-k] = chip_out;
        else if (chip_out !== word[9-k]) bad_hold++;
        if (chip_stb !== (c % per == 0)) bad_stb++;
        if (chip_idx !== 10'(k) || epoch !== (c == 0) || running !== 1'b1) bad_idx++;
        tick();
      end
      check($sformatf("vec%0d_chips", v), word, vecs[v].bits);
      check($sformatf("vec%0d_stb", v), bad_stb, 0);
      check($sformatf("vec%0d_idx_epoch", v), bad_idx, 0);
      check($sformatf("vec%0d_hold", v), bad_hold, 0);
    end

    // epoch period, PRN 2, 4 cycles/chip
    do_start(6'd2, 16'd3);
    n = 0;
    do begin
      tick();
      n++;
    end while (epoch !== 1'b1 && n < 5000);
    check("epoch_period", n, 4092);
    check("epoch_idx", chip_idx, 0);
    check("epoch_lfsr", {dut.r_g1, dut.r_g2}, 32'hFFFFF);

    // enable freeze mid-code, PRN 1, 2 cycles/chip
    do_start(6'd1, 16'd1);
    for (int c = 0; c < 4; c++) tick();
    check("frz_pre", {chip_stb, chip_idx}, {1'b1, 10'd2});
    en = 1'b0;
    bad_a = 0;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (chip_idx !== 10'd2 || chip_out !== 1'b0 || chip_stb !== 1'b0) bad_a++;
    end
    check("frz_hold", bad_a, 0);
    en = 1'b1;
    tick();
    check("frz_resume_tail", {chip_stb, chip_idx}, {1'b0, 10'd2});
    tick();
    check("frz_next_chip", {chip_stb, chip_idx}, {1'b1, 10'd3});
    n = 13;
    do begin
      tick();
      n++;
    end while (epoch !== 1'b1 && n < 5000);
    check("frz_epoch_delay", n, 2053);

    // invalid PRNs
    do_start(6'd0, 16'd0);
    check("bad0", {running, prn_err, chip_out, chip_stb, epoch}, {1'b0, 1'b1, 3'b000});
    do_start(6'd40, 16'd0);
    bad_a = 0;
    for (int c = 0; c < 10; c++) begin
      if (running !== 1'b0 || prn_err !== 1'b1 || chip_out !== 1'b0 || chip_stb !== 1'b0 || epoch !== 1'b0) bad_a++;
      tick();
    end
    check("bad40_quiet", bad_a, 0);
    do_start(6'd5, 16'd0);
    check("good5_recover", {running, prn_err, chip_stb, chip_out}, {1'b1, 1'b0, 1'b1, 1'b1});

    // div_val change mid-chip
    do_start(6'd1, 16'd2);
    tick();
    div_val = 16'd5;
    tick();
    check("div_c2", {chip_stb, chip_idx}, {1'b0, 10'd0});
    tick();
    check("div_c3", {chip_stb, chip_idx}, {1'b1, 10'd1});
    for (int c = 0; c < 5; c++) tick();
    check("div_c8", {chip_stb, chip_idx}, {1'b0, 10'd1});
    tick();
    check("div_c9", {chip_stb, chip_idx}, {1'b1, 10'd2});

    // reset and start together while running
    rst = 1'b1; start = 1'b1; prn_sel = 6'd3;
    tick();
    check("rst_start_run", {chip_out, chip_early, chip_late, chip_stb, epoch, running, prn_err, chip_idx}, 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("rst_start_after", running, 0);

    // full period of PRN 1 against the model, including the wrap
    gen_seq(2, 6);
    do_start(6'd1, 16'd0);
    bad_a = 0; bad_b = 0; bad_c = 0; bad_idx = 0;
    for (int c = 0; c < 1026; c++) begin
      k = c % 1023;
      if (chip_out !== mseq[k]) bad_a++;
      if (chip_idx !== 10'(k)) bad_idx++;
      if (k == 0 && (dut.r_g1 !== 10'h3FF || dut.r_g2 !== 10'h3FF)) bad_idx++;
`ifdef CA_EPL_EN
      if (chip_early !== mseq[(k + 1) % 1023]) bad_b++;
      if (chip_late !== ((c == 0) ? 1'b0 : mseq[(k + 1022) % 1023])) bad_c++;
`else
      if (chip_early !== 1'b0) bad_b++;
      if (chip_late !== 1'b0) bad_c++;
`endif
      tick();
    end
    check("full_prompt", bad_a, 0);
    check("full_idx_seed", bad_idx, 0);
    check("full_early", bad_b, 0);
    check("full_late", bad_c, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ca_code_nco_gen.md
# ca_code_nco_gen

Parametrised GPS L1 C/A Gold-code generator for one tracking channel. Selects any PRN 1–32 at run time, and runs the chip rate from a programmable per-chip cycle divider. Provides a chip strobe, a 10-bit code-phase index and an epoch pulse every 1023 chips. It sits between the correlator timing logic and the code-mixing multiplier, and supersedes the fixed PRN / fixed-divider / button-restart generator.

## Interface
- DIV_WIDTH, 16, width of the chip-period divider (clock cycles per chip = div_val+1)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: latch prn_sel, reload LFSRs to all-ones, begin at chip 0
- en  in  1  divider advance enable; low freezes code phase, outputs hold
- prn_sel  in  6  PRN number, valid 1..32
- div_val  in  DIV_WIDTH  cycles per chip minus 1; resampled at every chip boundary
- chip_out  out  1  prompt code chip (G1 stage 10 XOR G2 tap pair)
- chip_early  out  1  next chip (one chip ahead); see Configuration
- chip_late  out  1  previous chip (one chip behind); see Configuration
- chip_stb  out  1  one-cycle pulse on the first cycle of each new chip
- epoch  out  1  coincides with chip_stb when the new chip index is 0
- chip_idx  out  10  current chip index, 0..1022
- running  out  1  generator active
- prn_err  out  1  last start carried an invalid prn_sel

## Operation
- LFSRs g1[9:0] and g2[9:0]: stage n is bit n-1. Shift is g <= {g[8:0], fb}.
  - g1 feedback = g1[2]^g1[9].
  - g2 feedback = g2[1]^g2[2]^g2[5]^g2[7]^g2[8]^g2[9].
- Phase-selector taps (G2 stages, per IS-GPS-200), PRN 1..32:
  - PRN 1–16: 2&6, 3&7, 4&8, 5&9, 1&9, 2&10, 1&8, 2&9, 3&10, 2&3, 3&4, 5&6, 6&7, 7&8, 8&9, 9&10.
  - PRN 17–32: 1&4, 2&5, 3&6, 4&7, 5&8, 6&9, 1&3, 4&6, 5&7, 6&8, 7&9, 8&10, 1&6, 2&7, 3&8, 4&9.
- chip_out = g1[9]^g2[a-1]^g2[b-1], using taps from the latched PRN. It is a pure function of registered state and holds 0 while not running.
- States:
  - IDLE (running=0)
  - RUN (running=1)
- Transitions:
  - rst → IDLE.
  - start with prn_sel in 1..32 → RUN. Latch PRN, set g1=g2=10'h3FF, chip_idx=0, div_cnt=div_val, late register=0, prn_err=0.
  - start with prn_sel 0 or 33..63 → IDLE, prn_err=1. LFSRs are left unchanged.
- In RUN with en=1:
  - If div_cnt≠0, decrement it.
  - If div_cnt==0, shift both LFSRs, latch the old chip_out into the late register, chip_idx <= (chip_idx==1022) ? 0 : chip_idx+1, and div_cnt <= current div_val.
- en=0 holds div_cnt, LFSRs and chip_idx; no strobes are issued.
- Both LFSRs have period 1023, so the all-ones state recurs at chip_idx 0 every epoch. This is not forced; a bench assertion checks it.
- start while in RUN restarts immediately, with the same behaviour as from IDLE.

## Timing
- Reset values: chip_out=0, chip_early=0, chip_late=0, chip_stb=0, epoch=0, chip_idx=0, running=0, prn_err=0, g1=g2=10'h3FF, div_cnt=0.
- Start is registered:
  - Chip 0 is visible on chip_out the cycle after start.
  - chip_stb and epoch are both high in that same cycle.
- Each chip lasts exactly div_val+1 enabled cycles, using the div_val sampled at the previous boundary (or at start).
- chip_stb is asserted in the first cycle of the new chip. With div_val=0 and en=1, chip_stb is continuously high.
- epoch period = 1023·(div_val+1) enabled cycles for a constant div_val.
- Priority: rst > start > divider advance. Start in the same cycle as a boundary: the start wins and the shift is discarded.
- prn_sel is ignored except in the start cycle. div_val changes take effect only at the next boundary.

## Configuration
- CA_EPL_EN defined:
  - chip_early = the chip the next shift will produce, computed combinationally from the next LFSR state.
  - chip_late = the registered previous chip. It is 0 during chip 0 after a start and valid from chip 1 onwards.
- CA_EPL_EN undefined: chip_early and chip_late are tied to 0, and the late register and next-state logic are omitted.

## Test plan
- rst, then start with prn_sel=1, div_val=0, en=1 → chip_out over chips 0..9 = 1100100000 (octal 1440). chip_stb high every cycle; epoch high at chip_idx 0.
- start with prn_sel=2, div_val=3 → first 10 chips 1110010000 (octal 1620), each held 4 cycles. epoch recurs after 4092 cycles, and g1=g2=3FF at chip_idx 0.
- start with prn_sel=0, then prn_sel=40 → running=0, prn_err=1, chip_out=0, no strobes. A following start with prn_sel=5 clears prn_err within 1 cycle.
- PRN 1, div_val=1, en dropped for 7 cycles mid-chip → chip_idx and chip_out frozen; remaining chip length resumes correctly; epoch is delayed by exactly 7 cycles.
- Change div_val 2→5 mid-chip → current chip still lasts 3 cycles, next chip 6. Start asserted together with rst → outputs stay at reset values.
- CA_EPL_EN, PRN 1, div_val=0 → at chip k: chip_early = chip k+1, chip_late = chip k-1 (0 at k=0), across the wrap at chip_idx 1022→0.
